// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM state encoding and result-latency helper for the
// weight-stationary systolic tile.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } sa_state_e;

    // Cycles from an accepted activation beat until column c shows its result.
    function automatic int sa_latency(input int rows, input int cols, input int c, input bit deskew);
        return deskew ? rows + cols : rows + 1 + c;
    endfunction

endpackage

// File: rtl/sa_pe_ws.sv
// sa_pe_ws: one weight-stationary processing element -- held weight, signed
// multiply-accumulate into the passing partial sum, activation forwarded east.
module sa_pe_ws #(
    parameter int WW = 8,
    parameter int AW = 8,
    parameter int PW = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 w_we,
    input  logic                 dis,
    input  logic signed [WW-1:0] w_in,
    input  logic signed [AW-1:0] a_in,
    input  logic signed [PW-1:0] psum_in,
    output logic signed [AW-1:0] a_out,
    output logic signed [PW-1:0] psum_out
);

    logic signed [WW-1:0]    w_q;
    logic signed [WW+AW-1:0] prod;

    // Size casts of signed operands sign-extend, so the product is exact.
    assign prod = (WW+AW)'(w_q) * (WW+AW)'(a_in);

    // Weight writes are independent of the stall enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else if (w_we) begin
            w_q <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out    <= '0;
            psum_out <= '0;
        end else if (en) begin
            a_out    <= a_in;
            psum_out <= dis ? psum_in : psum_in + PW'(prod);
        end
    end

endmodule

// File: rtl/sa_tile_ws.sv
// sa_tile_ws: ROWS x COLS weight-stationary systolic tile with weight preload,
// input skew, stall/drain control. Define SA_OUTPUT_DESKEW_EN to align results.
module sa_tile_ws
    import sa_pkg::*;
#(
    parameter int ROWS              = 8,
    parameter int COLS              = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(ROWS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [COLS*WEIGHT_WIDTH-1:0]      w_row_flat,
    input  logic [COLS-1:0]                   col_disable,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic                              a_last,
    input  logic [ROWS*ACTIVATION_WIDTH-1:0]  a_vec_flat,
    input  logic [COLS*PARTIAL_SUM_WIDTH-1:0] psum_in_flat,
    output logic [COLS-1:0]                   out_valid,
    input  logic                              out_ready,
    output logic [COLS*PARTIAL_SUM_WIDTH-1:0] out_psum_flat,
    output logic [1:0]                        state
);

    localparam int WW      = WEIGHT_WIDTH;
    localparam int AW      = ACTIVATION_WIDTH;
    localparam int PW      = PARTIAL_SUM_WIDTH;
    localparam int TOK_LEN = ROWS + COLS;
    localparam int RCW     = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef SA_OUTPUT_DESKEW_EN
    localparam bit DESKEW  = 1'b1;
`else
    localparam bit DESKEW  = 1'b0;
`endif

    sa_state_e          st;
    logic [RCW-1:0]     row_cnt;
    logic [COLS-1:0]    col_dis;
    logic [TOK_LEN-1:0] tok;
    logic               stall, w_accept, a_accept;

    logic signed [AW-1:0] a_h [ROWS][COLS+1];
    logic signed [PW-1:0] p_v [ROWS+1][COLS];
    logic signed [PW-1:0] out_col [COLS];

    assign state    = st;
    assign w_ready  = (st == IDLE) || (st == LOAD);
    assign a_ready  = (st == COMPUTE) && !stall;
    assign w_accept = w_valid && w_ready;
    assign a_accept = a_valid && a_ready;
    assign stall    = (|out_valid) && !out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            row_cnt <= '0;
            col_dis <= '0;
        end else begin
            case (st)
                IDLE, LOAD: if (w_valid) begin
                    if (row_cnt == RCW'(ROWS - 1)) begin
                        st      <= COMPUTE;
                        row_cnt <= '0;
                        col_dis <= col_disable;
                    end else begin
                        st      <= LOAD;
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                COMPUTE: if (a_accept && a_last) st <= DRAIN;
                // Leave once the last token shifts out on this edge.
                DRAIN: if (!stall && tok[TOK_LEN-2:0] == '0) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    // One token per accepted vector; its position tracks the wavefront.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok <= '0;
        end else if (!stall) begin
            tok <= {tok[TOK_LEN-2:0], a_accept};
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic signed [AW-1:0] sr [r+1];
        // NOTE: skew stages are reset even though tokens qualify them, so an
        // aborted batch can never leak stale operands into the next one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) sr[i] <= '0;
            end else if (!stall) begin
                sr[0] <= a_accept ? a_vec_flat[r*AW +: AW] : '0;
                for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
            end
        end
        assign a_h[r][0] = sr[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        logic signed [PW-1:0] sr [c+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= c; i++) sr[i] <= '0;
            end else if (!stall) begin
                sr[0] <= a_accept ? psum_in_flat[c*PW +: PW] : '0;
                for (int i = 1; i <= c; i++) sr[i] <= sr[i-1];
            end
        end
        assign p_v[0][c] = sr[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sa_pe_ws #(.WW(WW), .AW(AW), .PW(PW)) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (!stall),
                .w_we     (w_accept && row_cnt == RCW'(r)),
                .dis      (col_dis[c]),
                .w_in     (w_row_flat[c*WW +: WW]),
                .a_in     (a_h[r][c]),
                .psum_in  (p_v[r][c]),
                .a_out    (a_h[r][c+1]),
                .psum_out (p_v[r+1][c])
            );
        end
    end

`ifdef SA_OUTPUT_DESKEW_EN
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign out_col[c] = p_v[ROWS][c];
        end else begin : g_dly
            logic signed [PW-1:0] sr [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) sr[i] <= '0;
                end else if (!stall) begin
                    sr[0] <= p_v[ROWS][c];
                    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
                end
            end
            assign out_col[c] = sr[D-1];
        end
    end
    assign out_valid = {COLS{tok[sa_latency(ROWS, COLS, 0, DESKEW) - 1]}};
`else
    for (genvar c = 0; c < COLS; c++) begin : g_direct
        assign out_col[c]   = p_v[ROWS][c];
        assign out_valid[c] = tok[sa_latency(ROWS, COLS, c, DESKEW) - 1];
    end
`endif

    for (genvar c = 0; c < COLS; c++) begin : g_pack
        assign out_psum_flat[c*PW +: PW] = out_col[c];
    end

endmodule

// File: tb/tb_sa_tile_ws.sv
// tb_sa_tile_ws: directed bench for sa_tile_ws with a per-column scoreboard
// of expected results checked as each column transfers.
module tb_sa_tile_ws;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int WW   = 8;
    localparam int AW   = 8;
    localparam int PW   = WW + AW + $clog2(ROWS);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                w_valid, w_ready;
    logic [COLS*WW-1:0]  w_row_flat;
    logic [COLS-1:0]     col_disable;
    logic                a_valid, a_ready, a_last;
    logic [ROWS*AW-1:0]  a_vec_flat;
    logic [COLS*PW-1:0]  psum_in_flat;
    logic [COLS-1:0]     out_valid;
    logic                out_ready;
    logic [COLS*PW-1:0]  out_psum_flat;
    logic [1:0]          state;

    int n_vec = 0;
    int n_err = 0;

    int              wt [ROWS][COLS];
    logic [COLS-1:0] dis_m;
    logic [PW-1:0]   exp_q [COLS][$];
    logic [PW-1:0]   mon_e;

    sa_tile_ws #(
        .ROWS(ROWS), .COLS(COLS), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AW), .PARTIAL_SUM_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_row_flat(w_row_flat), .col_disable(col_disable),
        .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last), .a_vec_flat(a_vec_flat),
        .psum_in_flat(psum_in_flat), .out_valid(out_valid), .out_ready(out_ready),
        .out_psum_flat(out_psum_flat), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int c);
`ifdef SA_OUTPUT_DESKEW_EN
        return ROWS + COLS;
`else
        return ROWS + 1 + c;
`endif
    endfunction

    function automatic logic [PW-1:0] model(input int c, input int a [ROWS], input int bias);
        longint s;
        s = longint'(bias);
        if (!dis_m[c])
            for (int r = 0; r < ROWS; r++) s += longint'(wt[r][c]) * longint'(a[r]);
        return s[PW-1:0];
    endfunction

    // Scoreboard pop: a transfer happens at the next posedge when valid && ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_ready === 1'b1) begin
            for (int c = 0; c < COLS; c++) begin
                if (out_valid[c] === 1'b1) begin
                    chk($sformatf("sb_avail_c%0d", c), exp_q[c].size() != 0, 1);
                    if (exp_q[c].size() != 0) begin
                        mon_e = exp_q[c].pop_front();
                        chk($sformatf("result_c%0d", c), out_psum_flat[c*PW +: PW], mon_e);
                    end
                end
            end
        end
    end

    task automatic load_weights(input logic [COLS-1:0] dis);
        int k;
        dis_m = dis;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) w_row_flat[c*WW +: WW] = WW'(wt[r][c]);
            col_disable = (r == ROWS - 1) ? dis : ~dis;
            w_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (w_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
            chk($sformatf("w_ready_row%0d", r), w_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("state_after_wrow%0d", r), state, (r == ROWS - 1) ? 2 : 1);
        end
        w_valid     = 1'b0;
        col_disable = '0;
    endtask

    task automatic send_vec(input int a [ROWS], input int bias [COLS], input bit last);
        int k;
        for (int r = 0; r < ROWS; r++) a_vec_flat[r*AW +: AW] = AW'(a[r]);
        for (int c = 0; c < COLS; c++) psum_in_flat[c*PW +: PW] = PW'(bias[c]);
        a_last  = last;
        a_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (a_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("a_ready_accept", a_ready, 1);
        if (a_ready === 1'b1)
            for (int c = 0; c < COLS; c++) exp_q[c].push_back(model(c, a, bias[c]));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        int tot;
        k = 0;
        @(negedge clk);
        while (state !== 2'd0 && k < 200) begin @(negedge clk); k++; end
        chk({tag, "_idle"}, state, 0);
        tot = 0;
        for (int c = 0; c < COLS; c++) tot += exp_q[c].size();
        chk({tag, "_sb_drained"}, tot, 0);
        @(posedge clk); #1;
    endtask

    int a_v [ROWS];
    int b_v [COLS];
    logic [COLS-1:0]    exp_mask;
    logic [COLS-1:0]    snap_v;
    logic [COLS*PW-1:0] snap_p;
    int k_w;

    initial begin
        rst_n = 1'b0; w_valid = 0; w_row_flat = '0; col_disable = '0;
        a_valid = 0; a_last = 0; a_vec_flat = '0; psum_in_flat = '0; out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_psum", out_psum_flat, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Identity weights, activations 1..N, bias 0: exact per-column latency and drain timing
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wt[r][c] = (r == c) ? 1 : 0;
        for (int r = 0; r < ROWS; r++) a_v[r] = r + 1;
        for (int c = 0; c < COLS; c++) b_v[c] = 0;
        load_weights('0);
        send_vec(a_v, b_v, 1'b1);
        a_valid = 0;
        for (int n = 0; n <= ROWS + COLS; n++) begin
            @(negedge clk);
            exp_mask = '0;
            for (int c = 0; c < COLS; c++) if (n == lat(c) - 1) exp_mask[c] = 1'b1;
            chk($sformatf("lat_valid_n%0d", n), out_valid, exp_mask);
            chk($sformatf("drain_state_n%0d", n), state, (n < ROWS + COLS) ? 3 : 0);
            @(posedge clk); #1;
        end
        wait_idle("ident");

        // Uniform weights with one disabled column: disabled column passes bias through
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wt[r][c] = 2;
        for (int r = 0; r < ROWS; r++) a_v[r] = 3;
        for (int c = 0; c < COLS; c++) b_v[c] = 5;
        load_weights(8'h08);
        send_vec(a_v, b_v, 1'b1);
        a_valid = 0;
        wait_idle("coldis");

        // Sign handling: most-negative operands, then -1 x 127
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wt[r][c] = -128;
        for (int r = 0; r < ROWS; r++) a_v[r] = -128;
        for (int c = 0; c < COLS; c++) b_v[c] = 0;
        load_weights('0);
        send_vec(a_v, b_v, 1'b1);
        a_valid = 0;
        wait_idle("neg128");
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wt[r][c] = -1;
        for (int r = 0; r < ROWS; r++) a_v[r] = 127;
        load_weights('0);
        send_vec(a_v, b_v, 1'b1);
        a_valid = 0;
        wait_idle("neg1");

        // Ten back-to-back random vectors with a four-cycle output stall
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wt[r][c] = int'($urandom_range(255)) - 128;
        load_weights('0);
        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < ROWS; r++) a_v[r] = int'($urandom_range(255)) - 128;
            for (int c = 0; c < COLS; c++) b_v[c] = int'($urandom_range(2000)) - 1000;
            send_vec(a_v, b_v, i == 9);
        end
        a_valid = 0;
        k_w = 0;
        @(negedge clk);
        while (out_valid === '0 && k_w < 50) begin @(negedge clk); k_w++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap_v = out_valid;
        snap_p = out_psum_flat;
        chk("stall_has_valid", |snap_v, 1);
        for (int s = 1; s < 4; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("stall_valid_hold%0d", s), out_valid, snap_v);
            chk($sformatf("stall_psum_hold%0d", s), out_psum_flat, snap_p);
            chk($sformatf("stall_state%0d", s), state, 3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle("stream");

        // Reset mid-batch with five vectors in flight
        load_weights('0);
        for (int i = 0; i < 5; i++) send_vec(a_v, b_v, 1'b0);
        a_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        for (int c = 0; c < COLS; c++) exp_q[c].delete();
        chk("midrst_state", state, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_psum", out_psum_flat, 0);
        chk("midrst_w_ready", w_ready, 1);
        chk("midrst_a_ready", a_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Activation beats offered in IDLE are ignored and create no results
        a_valid = 1'b1;
        a_last  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("idle_a_ready%0d", n), a_ready, 0);
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        chk("idle_state_after_a", state, 0);
        for (int n = 0; n < ROWS + COLS + 2; n++) begin
            @(negedge clk);
            chk($sformatf("idle_no_valid%0d", n), out_valid, 0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
